// File: rtl/mem_access_ctrl.sv
// Single-request bus initiator for the 13-bit ROM/RAM map.
// Runs one access at a time: address setup, a strobe stretched by wait states, then a one-cycle acknowledge.
module mem_access_ctrl #(
  parameter int ADDR_W   = 13,
  parameter int DATA_W   = 8,
  parameter int ROM_WAIT = 1,
  parameter int RAM_WAIT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ack,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] addr,
  output logic              rd,
  output logic              wr,
  output logic [DATA_W-1:0] data_out,
  output logic              data_oe,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rom_sel,
  input  logic              ram_sel
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_STROBE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [3:0] ROM_WAIT_C = 4'(ROM_WAIT);
  localparam logic [3:0] RAM_WAIT_C = 4'(RAM_WAIT);

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic              oe_q, oe_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              reject_s;

  // Writes to ROM, unmapped addresses and conflicting selects are all refused.
  function automatic logic access_reject(input logic is_write, input logic rom, input logic ram);
    return (rom & ram) | (~rom & ~ram) | (is_write & rom);
  endfunction

  assign reject_s = access_reject(we_q, rom_sel, ram_sel);

  // Next-state and output-register logic for the access sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    busy_d  = busy_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    oe_d    = oe_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          state_d = ST_SETUP;
          we_d    = we;
          addr_d  = req_addr;
          dout_d  = wdata;
          busy_d  = 1'b1;
          oe_d    = we;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (reject_s) begin
          state_d = ST_DONE;
          ack_d   = 1'b1;
          err_d   = 1'b1;
        end else begin
          state_d = ST_STROBE;
          cnt_d   = rom_sel ? ROM_WAIT_C : RAM_WAIT_C;
          rd_d    = ~we_q;
          wr_d    = we_q;
        end
      end
      ST_STROBE: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_DONE;
          ack_d   = 1'b1;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          if (!we_q) begin
            rdata_d = data_in;
          end else begin
            rdata_d = rdata_q;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE: begin
        // data_oe stays up through this cycle to hold write data past wr.
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        oe_d    = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        oe_d    = 1'b0;
      end
    endcase
  end

  // State and registered bus outputs; reset abandons any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      oe_q    <= 1'b0;
      addr_q  <= '0;
      dout_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      oe_q    <= oe_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      rdata_q <= rdata_d;
    end
  end

  assign ack      = ack_q;
  assign err      = err_q;
  assign rdata    = rdata_q;
  assign busy     = busy_q;
  assign addr     = addr_q;
  assign rd       = rd_q;
  assign wr       = wr_q;
  assign data_out = dout_q;
  assign data_oe  = oe_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural address decoder and an expected-result queue.
module tb_mem_access_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic        we;
  logic [12:0] req_addr;
  logic [7:0]  wdata;
  logic        ack;
  logic        err;
  logic [7:0]  rdata;
  logic        busy;
  logic [12:0] addr;
  logic        rd;
  logic        wr;
  logic [7:0]  data_out;
  logic        data_oe;
  logic [7:0]  data_in;
  logic        rom_sel;
  logic        ram_sel;
  logic [1:0]  dec_mode;

  typedef struct {
    logic       err;
    logic [7:0] rdata;
    int         lat;
  } exp_t;

  exp_t       sb[$];
  int         errors = 0;
  int         checks = 0;
  logic [7:0] model_rdata;

  mem_access_ctrl #(.ADDR_W(13), .DATA_W(8), .ROM_WAIT(1), .RAM_WAIT(0)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .req_addr(req_addr), .wdata(wdata),
    .ack(ack), .err(err), .rdata(rdata), .busy(busy), .addr(addr), .rd(rd), .wr(wr),
    .data_out(data_out), .data_oe(data_oe), .data_in(data_in),
    .rom_sel(rom_sel), .ram_sel(ram_sel)
  );

  // Decoder: mode 0 = real map, 1 = nothing selected, 2 = both selected.
  assign rom_sel = (dec_mode == 2'd2) ? 1'b1 : (dec_mode == 2'd1) ? 1'b0 : (addr < 13'h1800);
  assign ram_sel = (dec_mode == 2'd2) ? 1'b1 : (dec_mode == 2'd1) ? 1'b0 : (addr >= 13'h1800);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic do_access(input logic w, input logic [12:0] a, input logic [7:0] wd,
                           input logic [7:0] din, input logic [1:0] mode, input int lat,
                           input logic exp_err, input bit spur);
    exp_t e;
    bit   seen;
    int   c;
    logic strobe_s;
    dec_mode = mode;
    data_in  = din;
    if (!w && !exp_err) model_rdata = din;
    e.err   = exp_err;
    e.rdata = model_rdata;
    e.lat   = lat;
    sb.push_back(e);
    req = 1'b1; we = w; req_addr = a; wdata = wd;
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0; req_addr = 13'h0000; wdata = 8'h00;
    c = 1;
    seen = 1'b0;
    while (!seen && c <= 12) begin
      if (spur && (c == 1 || c == 3)) begin
        req = 1'b1; we = 1'b1; req_addr = 13'h1900;
      end else begin
        req = 1'b0;
      end
      strobe_s = !exp_err && c >= 2 && c <= lat - 1;
      chk("busy", 16'(busy), 16'(c <= lat));
      chk("ack_timing", 16'(ack), 16'(c == lat));
      chk("rd", 16'(rd), 16'(!w && strobe_s));
      chk("wr", 16'(wr), 16'(w && strobe_s));
      chk("data_oe", 16'(data_oe), 16'(w && c <= lat));
      chk("addr", 16'(addr), 16'(a));
      chk("data_out", 16'(data_out), 16'(wd));
      if (ack === 1'b1) begin
        seen = 1'b1;
        e = sb.pop_front();
        chk("err", 16'(err), 16'(e.err));
        chk("rdata", 16'(rdata), 16'(e.rdata));
        chk("latency", 16'(c), 16'(e.lat));
      end else begin
        @(posedge clk); #1;
        c++;
      end
    end
    if (!seen) begin
      chk("ack_seen", 16'(seen), 16'd1);
      if (sb.size() > 0) void'(sb.pop_front());
    end
    @(posedge clk); #1;
    req = 1'b0;
    chk("idle_busy", 16'(busy), 16'd0);
    chk("idle_ack", 16'(ack), 16'd0);
    chk("idle_oe", 16'(data_oe), 16'd0);
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b0; we = 1'b0; req_addr = 13'h0000; wdata = 8'h00;
    data_in = 8'h00; dec_mode = 2'd0; model_rdata = 8'h00;
    #12;
    chk("rst_ack", 16'(ack), 16'd0);
    chk("rst_err", 16'(err), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_rd", 16'(rd), 16'd0);
    chk("rst_wr", 16'(wr), 16'd0);
    chk("rst_oe", 16'(data_oe), 16'd0);
    chk("rst_addr", 16'(addr), 16'd0);
    chk("rst_dout", 16'(data_out), 16'd0);
    chk("rst_rdata", 16'(rdata), 16'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_access(1'b0, 13'h1800, 8'h12, 8'hA5, 2'd0, 3, 1'b0, 1'b0);
    do_access(1'b0, 13'h0010, 8'h34, 8'h5A, 2'd0, 4, 1'b0, 1'b0);
    do_access(1'b1, 13'h1FFF, 8'h3C, 8'hEE, 2'd0, 3, 1'b0, 1'b0);
    do_access(1'b1, 13'h17FF, 8'hFF, 8'hDD, 2'd0, 2, 1'b1, 1'b0);
    do_access(1'b0, 13'h1800, 8'h56, 8'h77, 2'd0, 3, 1'b0, 1'b1);
    do_access(1'b0, 13'h1ABC, 8'h78, 8'h11, 2'd0, 3, 1'b0, 1'b0);
    do_access(1'b0, 13'h0100, 8'h9A, 8'h22, 2'd1, 2, 1'b1, 1'b0);
    do_access(1'b0, 13'h1900, 8'hBC, 8'h33, 2'd2, 2, 1'b1, 1'b0);
    do_access(1'b0, 13'h17FF, 8'hDE, 8'hC3, 2'd0, 4, 1'b0, 1'b0);
    do_access(1'b0, 13'h0000, 8'h01, 8'h81, 2'd0, 4, 1'b0, 1'b0);

    // Reset in the second strobe cycle of a ROM read.
    dec_mode = 2'd0; data_in = 8'h44;
    req = 1'b1; we = 1'b0; req_addr = 13'h0020; wdata = 8'h00;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_rd_c2", 16'(rd), 16'd1);
    @(posedge clk); #1;
    chk("pre_rst_rd_c3", 16'(rd), 16'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rd", 16'(rd), 16'd0);
    chk("async_busy", 16'(busy), 16'd0);
    chk("async_addr", 16'(addr), 16'd0);
    chk("async_oe", 16'(data_oe), 16'd0);
    chk("async_rdata", 16'(rdata), 16'd0);
    model_rdata = 8'h00;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("no_ack_in_rst", 16'(ack), 16'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("no_ack_after_rst", 16'(ack), 16'd0);
    do_access(1'b0, 13'h1800, 8'h00, 8'h99, 2'd0, 3, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Bus initiator for the 13-bit CPU memory map: accepts single read/write requests from the CPU core, drives the shared address, strobes and data bus toward ROM (0000H–17FFH) and RAM (1800H–1FFFH), and returns read data with an acknowledge. It sits between the core and the memories. It drives the address into the external ROM/RAM select decoder and consumes that decoder's `rom_sel`/`ram_sel` outputs to choose wait states and reject illegal accesses.

## Interface
- `ADDR_W`, 13, address width.
- `DATA_W`, 8, data width.
- `ROM_WAIT`, 1, extra strobe cycles for ROM accesses (0–15).
- `RAM_WAIT`, 0, extra strobe cycles for RAM accesses (0–15).

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req`  in  1  core request, sampled only in IDLE.
- `we`  in  1  1 = write, 0 = read; sampled with `req`.
- `req_addr`  in  ADDR_W  request address; sampled with `req`.
- `wdata`  in  DATA_W  write data; sampled with `req`.
- `ack`  out  1  one-cycle completion pulse.
- `err`  out  1  valid with `ack`; 1 = access rejected.
- `rdata`  out  DATA_W  read data; valid from `ack` until the next read completes.
- `busy`  out  1  high from acceptance until the cycle after `ack`.
- `addr`  out  ADDR_W  memory address, also fed to the select decoder.
- `rd`  out  1  read strobe.
- `wr`  out  1  write strobe.
- `data_out`  out  DATA_W  write data to the bus.
- `data_oe`  out  1  bus drive enable for `data_out`.
- `data_in`  in  DATA_W  read data from the bus.
- `rom_sel`  in  1  decoder output: ROM selected.
- `ram_sel`  in  1  decoder output: RAM selected.

## Operation
- States: IDLE, SETUP, STROBE, DONE.
- **IDLE:** `busy`=0. On `req`=1:
  - latch `req_addr`, `we` and `wdata`;
  - go to SETUP.
- **SETUP (1 cycle):**
  - `addr` = latched address; the decoder settles.
  - At the end of the cycle, sample `rom_sel`/`ram_sel`.
  - Write with `rom_sel`=1, or neither select high → set the error flag and go to DONE with no strobe.
  - Both selects high → treated as an error.
  - Otherwise load the 4-bit wait counter with ROM_WAIT or RAM_WAIT and go to STROBE.
- **STROBE:**
  - `rd` (read) or `wr` (write) held high for the whole state, i.e. WAIT+1 cycles.
  - The counter decrements each cycle.
  - At the edge where the counter is 0: for reads, capture `data_in` into `rdata`; go to DONE.
- **DONE (1 cycle):**
  - `ack`=1, `err` = error flag, `rd`/`wr`=0, `addr` held.
  - Next state IDLE; the error flag clears.
- Write data path:
  - `data_out` = latched `wdata` whenever busy.
  - `data_oe`=1 in SETUP, STROBE and DONE for writes only, giving one cycle of setup and one of hold around `wr`.
- `rdata` is unchanged by writes and by rejected accesses.
- `req` in any state other than IDLE, including the DONE cycle, is ignored. No queueing. The core must wait for `ack` before issuing the next request.

## Timing
- Reset values (asynchronous, immediate on `rst_n`=0):
  - state IDLE; counter 0; error flag 0;
  - `ack`, `err`, `busy`, `rd`, `wr`, `data_oe` = 0;
  - `addr`, `data_out`, `rdata` = 0.
- Take `req` sampled at edge 0 as the reference:
  - SETUP occupies cycle 1.
  - STROBE occupies cycles 2 … 2+WAIT.
  - `ack` is high in cycle 3+WAIT.
- Latency to `ack`: 3+WAIT cycles for a legal access; 2 cycles for a rejected one.
- Back-to-back: the earliest next `req` acceptance is the cycle after `ack`, giving a throughput of one access per 4+WAIT cycles.
- `busy` is high from cycle 1 through the `ack` cycle.
- Reset asserted mid-access: strobes and `data_oe` drop immediately, no `ack` is issued, and the access is lost.

## Test plan
- **RAM read:** `req`, `we`=0, `req_addr`=13'h1800, `data_in`=8'hA5, defaults.
  - `rd` high in cycle 2 only.
  - `ack`=1, `err`=0 in cycle 3.
  - `rdata`=8'hA5.
- **ROM read:** `req_addr`=13'h0010, `data_in`=8'h5A, ROM_WAIT=1.
  - `rd` high in cycles 2–3.
  - `ack` in cycle 4.
  - `rdata`=8'h5A.
- **RAM write:** `req_addr`=13'h1FFF, `wdata`=8'h3C.
  - `data_oe` high in cycles 1–3.
  - `wr` high in cycle 2 only, with `data_out`=8'h3C.
  - `ack`, `err`=0 in cycle 3.
- **ROM write:** `req_addr`=13'h17FF, `wdata`=8'hFF.
  - `wr` never asserted.
  - `ack`=1, `err`=1 in cycle 2.
  - `rdata` unchanged.
- **Request while busy:** second `req` pulses in cycles 1 and 3 of a RAM read.
  - Both ignored.
  - Exactly one `ack`.
  - A new `req` in cycle 4 is accepted.
- **Reset mid-strobe:** `rst_n` low during cycle 3 of a ROM read.
  - `rd`, `busy`, `addr` go to 0 asynchronously.
  - No `ack`.
  - After release, a fresh RAM read completes normally.
